// File: rtl/seq_serializer_if.sv
// Parallel-word input and serial-bit output bundle for seq_serializer.
// The design side uses slave; whatever drives din and en uses master.
interface seq_serializer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             en;
    logic             x;
    logic             x_valid;
    logic [LW-1:0]    level;

    modport master (
        output din, din_valid, en,
        input  din_ready, x, x_valid, level
    );

    modport slave (
        input  din, din_valid, en,
        output din_ready, x, x_valid, level
    );
endinterface

// File: rtl/seq_serializer.sv
// Buffers WIDTH-bit words in a small FIFO and shifts them out MSB first.
// When a word ends and another is queued, the next word follows with no idle cycle.
module seq_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_serializer_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic full_c;
    logic push_c;
    logic pop_c;

    assign full_c        = (level_q == LW'(DEPTH));
    assign push_c        = bus.din_valid && !full_c;
    assign bus.din_ready = !full_c;
    assign bus.level     = level_q;

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Shifter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Shifter next state: load a word from IDLE or back-to-back at the last bit
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        pop_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en && (level_q != '0)) begin
                    pop_c     = 1'b1;
                    sr_nxt    = mem[rd_ptr];
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.en) begin
                    if (cnt == CW'(WIDTH - 1)) begin
                        if (level_q != '0) begin
                            pop_c   = 1'b1;
                            sr_nxt  = mem[rd_ptr];
                            cnt_nxt = '0;
                        end else begin
                            sr_nxt    = '0;
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end
                    end else begin
                        sr_nxt  = {sr[WIDTH-2:0], 1'b0};
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // x is taken from registered state only; x_valid also needs the live en
    assign bus.x       = (state == SHIFT) && sr[WIDTH-1];
    assign bus.x_valid = (state == SHIFT) && bus.en;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: reset, single word, back-to-back, full FIFO,
// pause, mid-word reset and push on the edge that retires a word.
module tb_seq_serializer;
    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    seq_serializer_if #(.WIDTH(8), .DEPTH(4)) bus ();

    seq_serializer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; sample and drive 2 time units after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Expect n payload bits, bits[n-1] first, one per cycle with en high.
    task automatic expect_bits(input string tag, input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_xv"}, 32'(bus.x_valid), 32'd1);
            check({tag, "_x"},  32'(bus.x),       32'(bits[n-1-i]));
            cyc();
        end
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_idle_xv"}, 32'(bus.x_valid), 32'd0);
        check({tag, "_idle_x"},  32'(bus.x),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] words [5];
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        cyc();
        cyc();
        check("rst_level", 32'(bus.level),     32'd0);
        check("rst_ready", 32'(bus.din_ready), 32'd1);
        expect_idle("rst");

        // Single word; first push on the first edge after release
        rst           = 1'b0;
        bus.en        = 1'b1;
        bus.din       = 8'hB5;
        bus.din_valid = 1'b1;
        cyc();
        bus.din_valid = 1'b0;
        #1;
        check("b5_level_push", 32'(bus.level), 32'd1);
        expect_idle("b5_pre");
        cyc();
        check("b5_level_pop", 32'(bus.level), 32'd0);
        expect_bits("b5", 32'hB5, 8);
        expect_idle("b5_post");

        // Back-to-back words form one contiguous 16-bit run
        bus.din       = 8'hD0;
        bus.din_valid = 1'b1;
        cyc();
        bus.din = 8'hB0;
        cyc();
        bus.din_valid = 1'b0;
        #1;
        expect_bits("d0b0", 32'hD0B0, 16);
        expect_idle("d0b0_post");

        // Fill with en low; the fifth word must be refused
        bus.en = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            bus.din       = words[i];
            bus.din_valid = 1'b1;
            cyc();
            check($sformatf("full_level%0d", i), 32'(bus.level),     32'((i < 4) ? i + 1 : 4));
            check($sformatf("full_ready%0d", i), 32'(bus.din_ready), 32'((i < 3) ? 1 : 0));
            check($sformatf("full_xv%0d", i),    32'(bus.x_valid),   32'd0);
        end
        bus.din_valid = 1'b0;
        bus.en        = 1'b1;
        #1;
        cyc();
        check("drain_level", 32'(bus.level), 32'd3);
        expect_bits("drain", 32'h11223344, 32);
        expect_idle("drain_post");
        check("drain_level_end", 32'(bus.level),     32'd0);
        check("drain_ready_end", 32'(bus.din_ready), 32'd1);

        // Pause for 3 cycles after the second bit of F0
        bus.din       = 8'hF0;
        bus.din_valid = 1'b1;
        cyc();
        bus.din_valid = 1'b0;
        #1;
        cyc();
        expect_bits("f0_head", 32'b11, 2);
        bus.en = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pause_x%0d", i),  32'(bus.x),       32'd1);
            check($sformatf("pause_xv%0d", i), 32'(bus.x_valid), 32'd0);
            cyc();
        end
        bus.en = 1'b1;
        #1;
        expect_bits("f0_tail", 32'b110000, 6);
        expect_idle("f0_post");

        // Reset after 3 bits of AA while 55 is queued
        bus.din       = 8'hAA;
        bus.din_valid = 1'b1;
        cyc();
        bus.din = 8'h55;
        cyc();
        bus.din_valid = 1'b0;
        #1;
        check("aa_level", 32'(bus.level), 32'd1);
        expect_bits("aa_head", 32'b101, 3);
        rst = 1'b1;
        #1;
        check("mrst_level", 32'(bus.level),     32'd0);
        check("mrst_ready", 32'(bus.din_ready), 32'd1);
        expect_idle("mrst");
        cyc();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("post_rst_xv%0d", i),    32'(bus.x_valid), 32'd0);
            check($sformatf("post_rst_level%0d", i), 32'(bus.level),   32'd0);
            cyc();
        end
        bus.din       = 8'h3C;
        bus.din_valid = 1'b1;
        cyc();
        bus.din_valid = 1'b0;
        #1;
        cyc();
        expect_bits("3c", 32'h3C, 8);
        expect_idle("3c_post");

        // Push on the retire edge of 81 while C3 is queued
        bus.din       = 8'h81;
        bus.din_valid = 1'b1;
        cyc();
        bus.din = 8'hC3;
        cyc();
        bus.din_valid = 1'b0;
        #1;
        check("sim_level_q", 32'(bus.level), 32'd1);
        expect_bits("81_head", 32'b1000000, 7);
        bus.din       = 8'hE7;
        bus.din_valid = 1'b1;
        #1;
        check("81_last_xv", 32'(bus.x_valid), 32'd1);
        check("81_last_x",  32'(bus.x),       32'd1);
        cyc();
        bus.din_valid = 1'b0;
        #1;
        check("sim_level", 32'(bus.level), 32'd1);
        expect_bits("c3e7", 32'hC3E7, 16);
        expect_idle("c3e7_post");
        check("sim_level_end", 32'(bus.level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
